sub_matrix_seq: RTL and testbench
=================================

# sub_matrix_seq

Sequential row-wise matrix subtractor for the coprocessor datapath: on `start` it fetches row pairs from two matrix row stores and computes C = A − B element by element. It writes each result row back through a write port and reports per-row and sticky overflow. It is the subtract-direction counterpart of the combinational row adder and uses the same row format: 40-bit rows of five signed 8-bit elements, element 0 in bits [39:32] and element 4 in bits [7:0].

## Interface
- `ROWS`, 5: rows per matrix; address width `AW = $clog2(ROWS)` (min 1).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `busy`  out  1  high from first READ cycle through last WRITE cycle.
- `done`  out  1  one-cycle pulse when all rows are written.
- `rd_en`  out  1  read strobe to both row stores.
- `rd_addr`  out  AW  row index being read.
- `rd_data_a`  in  40  row of A, valid the cycle after `rd_en`.
- `rd_data_b`  in  40  row of B, valid the cycle after `rd_en`.
- `wr_en`  out  1  result write strobe.
- `wr_addr`  out  AW  result row index.
- `wr_data`  out  40  result row.
- `ovf`  out  1  sticky: any element of any row overflowed in this operation.
- `ovf_rows`  out  ROWS  bit r set if row r had any element overflow.

## Operation
- FSM states: IDLE, READ, CALC, WRITE, DONE. Row counter `row` runs 0..ROWS-1.
- IDLE: if `start`, clear `ovf`, `ovf_rows`, `row`, then go to READ. Otherwise stay in IDLE.
- READ: `rd_en=1`, `rd_addr=row`. Go to CALC.
- CALC: capture both data inputs and compute five element differences into a result register. Update `ovf_rows[row]` and `ovf`. Go to WRITE.
- WRITE: `wr_en=1`, `wr_addr=row`, `wr_data=result`. If `row==ROWS-1`, go to DONE. Otherwise increment `row` and go to READ.
- DONE: `done=1`. Go to IDLE.
- Element arithmetic: 9-bit signed `d = {a[7],a} − {b[7],b}`. Overflow when `d[8] != d[7]`. Result element is `d[7:0]`, subject to the Configuration feature.
- `start` is ignored in every state except IDLE. An accepted `start` in the cycle after DONE begins a new operation.
- `ovf` and `ovf_rows` hold their values after DONE until the next accepted `start`.
- `rd_addr`, `wr_addr` and `wr_data` are don't-care while their strobe is low. They are driven 0 in IDLE.

## Timing
- Reset values: state IDLE, `row=0`, `busy=0`, `done=0`, `rd_en=0`, `wr_en=0`, `rd_addr=0`, `wr_addr=0`, `wr_data=0`, `ovf=0`, `ovf_rows=0`.
- Outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Per row: 3 cycles (READ, CALC, WRITE). Read latency into the block is exactly 1 cycle.
- If `start` is sampled high at edge k: READ for row 0 occurs in cycle k+1. The row-r write occurs in cycle k+3+3r. `done` is high in cycle k+1+3·ROWS, which is 16 cycles after the start edge for ROWS=5. The earliest next READ is k+3+3·ROWS.
- `busy` is high in cycles k+1 through k+3·ROWS.
- Reset mid-operation immediately drops `rd_en`, `wr_en`, `busy` and `done`, and returns the FSM to IDLE. Rows already written are not rolled back, and `ovf`/`ovf_rows` are cleared.

## Configuration
- `SUB_SAT_EN` defined: an overflowing element saturates. Positive overflow (`d[8]=0`) gives 0x7F. Negative overflow (`d[8]=1`) gives 0x80.
- `SUB_SAT_EN` undefined: the element wraps to `d[7:0]`.
- Overflow flags behave identically in both builds.

## Test plan
- Reset during idle and again mid-row-2 → all outputs reach their reset values without a clock edge. A fresh `start` afterwards completes all 5 rows.
- A rows all 0x0A0B0C0D0E, B rows all 0x0101010101, `start` at edge k → 5 writes at k+3,6,9,12,15, each 0x090A0B0C0D. `wr_addr` 0..4. `done` at k+16. `ovf=0`, `ovf_rows=0`.
- A row 2 = 0x7F00000080, B row 2 = 0x8000000001, other rows zero → row 2 result 0xFF0000007F when wrapped, 0x7F00000080 with `SUB_SAT_EN`. `ovf=1`, `ovf_rows=5'b00100`.
- A = B = 0x80807F7F00 → all results 0x0000000000, no overflow. This checks equal-extreme operands.
- `start` held high continuously → `start` is ignored while busy and in DONE. A new operation begins every 3·ROWS+2 cycles. `ovf` is cleared at each accepted start.
- Read data changed in the cycles without `rd_en` → results depend only on the data present in the cycle after `rd_en`.

Source files
------------

// File: rtl/sub_matrix_seq.sv
// Sequential row-wise matrix subtractor C = A - B over five signed 8-bit lanes.
// Define SUB_SAT_EN to saturate overflowing lanes instead of wrapping.
module sub_matrix_seq #(
    parameter  int ROWS = 5,
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [39:0]     rd_data_a,
    input  logic [39:0]     rd_data_b,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [39:0]     wr_data,
    output logic            ovf,
    output logic [ROWS-1:0] ovf_rows
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   row;
    logic [39:0]     result;
    logic [4:0][8:0] d;
    logic [4:0]      lane_ovf;
    logic [39:0]     diff;

    always_comb begin
        d        = '0;
        lane_ovf = '0;
        diff     = '0;
        for (int i = 0; i < 5; i++) begin
            d[i] = {rd_data_a[8*i+7], rd_data_a[8*i +: 8]}
                 - {rd_data_b[8*i+7], rd_data_b[8*i +: 8]};
            lane_ovf[i] = d[i][8] ^ d[i][7];
`ifdef SUB_SAT_EN
            diff[8*i +: 8] = lane_ovf[i]
                           ? (d[i][8] ? 8'h80 : 8'h7F)
                           : d[i][7:0];
`else
            diff[8*i +: 8] = d[i][7:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            result   <= '0;
            ovf      <= 1'b0;
            ovf_rows <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ovf      <= 1'b0;
                        ovf_rows <= '0;
                        row      <= '0;
                        state    <= READ;
                    end
                end
                READ: state <= CALC;
                CALC: begin
                    result <= diff;
                    if (|lane_ovf) begin
                        ovf_rows[row] <= 1'b1;
                        ovf           <= 1'b1;
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    if (row == AW'(ROWS - 1)) begin
                        state <= DONE;
                    end else begin
                        row   <= row + AW'(1);
                        state <= READ;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register; address/data are
    // gated so they read as zero whenever their strobe is low.
    assign busy    = (state == READ) || (state == CALC) || (state == WRITE);
    assign done    = (state == DONE);
    assign rd_en   = (state == READ);
    assign wr_en   = (state == WRITE);
    assign rd_addr = rd_en ? row : '0;
    assign wr_addr = wr_en ? row : '0;
    assign wr_data = wr_en ? result : '0;

endmodule

// File: tb/tb_sub_matrix_seq.sv
// Table-driven bench for sub_matrix_seq with row-store model.
// Expected values are hand-computed; SUB_SAT_EN selects saturated results.
module tb_sub_matrix_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, rd_en, wr_en, ovf;
    logic [2:0]  rd_addr, wr_addr;
    logic [39:0] rd_data_a, rd_data_b, wr_data;
    logic [4:0]  ovf_rows;

    logic [39:0] mem_a [5];
    logic [39:0] mem_b [5];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0][39:0] a;
        logic [4:0][39:0] b;
        logic [4:0][39:0] y;
        logic             ovf;
        logic [4:0]       rows;
    } vec_t;

    vec_t v [4];

    sub_matrix_seq #(.ROWS(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ovf(ovf), .ovf_rows(ovf_rows)
    );

    always #5 clk = ~clk;

    // Row stores: valid data only in the cycle after rd_en, noise otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end else begin
            rd_data_a <= {8'($urandom()), $urandom()};
            rd_data_b <= {8'($urandom()), $urandom()};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ctrl", {60'd0, busy, done, rd_en, wr_en}, 64'd0);
        chk("rst_addr", {58'd0, rd_addr, wr_addr}, 64'd0);
        chk("rst_wdata", {24'd0, wr_data}, 64'd0);
        chk("rst_ovf", {58'd0, ovf, ovf_rows}, 64'd0);
    endtask

    task automatic load(input vec_t x);
        for (int r = 0; r < 5; r++) begin
            mem_a[r] = x.a[r];
            mem_b[r] = x.b[r];
        end
    endtask

    task automatic run_op(input vec_t x);
        logic eb, er, ew, ed;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            eb = (t <= 15);
            er = (t <= 15) && ((t - 1) % 3 == 0);
            ew = (t <= 15) && (t % 3 == 0);
            ed = (t == 16);
            chk("ctrl", {60'd0, busy, rd_en, wr_en, done},
                {60'd0, eb, er, ew, ed});
            if (er) chk("rd_addr", 64'(rd_addr), 64'((t - 1) / 3));
            if (ew) begin
                chk("wr_addr", 64'(wr_addr), 64'((t - 3) / 3));
                chk("wr_data", 64'(wr_data), 64'(x.y[(t - 3) / 3]));
            end
        end
        chk("ovf", 64'(ovf), 64'(x.ovf));
        chk("ovf_rows", 64'(ovf_rows), 64'(x.rows));
    endtask

    initial begin
        v[0].a = {5{40'h0A0B0C0D0E}};
        v[0].b = {5{40'h0101010101}};
        v[0].y = {5{40'h090A0B0C0D}};
        v[0].ovf = 1'b0;
        v[0].rows = 5'b00000;

        v[1].a = '0; v[1].b = '0; v[1].y = '0;
        v[1].a[2] = 40'h7F00000080;
        v[1].b[2] = 40'h8000000001;
`ifdef SUB_SAT_EN
        v[1].y[2] = 40'h7F00000080;
`else
        v[1].y[2] = 40'hFF0000007F;
`endif
        v[1].ovf = 1'b1;
        v[1].rows = 5'b00100;

        v[2].a = {5{40'h80807F7F00}};
        v[2].b = {5{40'h80807F7F00}};
        v[2].y = '0;
        v[2].ovf = 1'b0;
        v[2].rows = 5'b00000;

        v[3].a = '0; v[3].b = '0; v[3].y = '0;
        v[3].b[0] = 40'h8000000000;
        v[3].a[4] = 40'h807F010203;
        v[3].b[4] = 40'h01FF0101FE;
`ifdef SUB_SAT_EN
        v[3].y[0] = 40'h7F00000000;
        v[3].y[4] = 40'h807F000105;
`else
        v[3].y[0] = 40'h8000000000;
        v[3].y[4] = 40'h7F80000105;
`endif
        v[3].ovf = 1'b1;
        v[3].rows = 5'b10001;

        rst = 1'b1;
        start = 1'b0;
        load(v[0]);
        #3;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load(v[i]);
            run_op(v[i]);
        end

        // Asynchronous reset while idle clears the sticky flags.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset during the row-2 write, then a clean operation.
        load(v[1]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
        end
        chk("mid_wr", {62'd0, wr_en, ovf}, {62'd0, 1'b1, 1'b1});
        #2 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;
        load(v[0]);
        run_op(v[0]);

        // start held high: one operation every 17 cycles.
        load(v[1]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 52; t++) begin
            @(negedge clk);
            chk("hold_done", 64'(done),
                64'(t == 16 || t == 33 || t == 50));
            if (t == 17) chk("hold_ovf_kept", 64'(ovf), 64'd1);
            if (t == 18) chk("hold_ovf_clr", 64'(ovf), 64'd0);
            if (t == 2) chk("hold_busy", 64'(busy), 64'd1);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("final_idle", {62'd0, busy, done}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
